instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder, the inverse of the pipeline's instruction decoder: it accepts decoded fields (format, opcode, func3, func7, register indices, full-width immediate) and emits the packed 32-bit instruction word with the program address it belongs at. It is used by the program loader and self-test path to build instruction-memory images on-chip. Transfers use valid/ready handshakes on both sides, with full back-pressure. An optional checker flags immediates that cannot be encoded.

---
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: decoded fields in, packed instruction word plus program address out.
// Optional immediate range checker is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [31:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         instr,
  output logic [31:0]         out_addr,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [2:0]  FMT_R   = 3'd0;
  localparam logic [2:0]  FMT_I   = 3'd1;
  localparam logic [2:0]  FMT_S   = 3'd2;
  localparam logic [2:0]  FMT_B   = 3'd3;
  localparam logic [2:0]  FMT_U   = 3'd4;
  localparam logic [2:0]  FMT_J   = 3'd5;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe freezes only when the presented word is not taken.
  logic stall;
  logic out_fire;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign out_fire = out_valid && out_ready;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [2:0]  s1_func3;
  logic [6:0]  s1_func7;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_fmt    <= fmt;
      s1_opcode <= opcode;
      s1_func3  <= func3;
      s1_func7  <= func7;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_imm    <= imm;
    end
  end

  logic        s1_shift;
  logic [31:0] enc;

  assign s1_shift = (s1_fmt == FMT_I) && (s1_opcode == OP_IMM) &&
                    ((s1_func3 == 3'd1) || (s1_func3 == 3'd5));

  always_comb begin
    enc = NOP;
    case (s1_fmt)
      FMT_R: enc = {s1_func7, s1_rs2, s1_rs1, s1_func3, s1_rd, s1_opcode};
      FMT_I: begin
        if (s1_shift) enc = {s1_func7, s1_imm[4:0], s1_rs1, s1_func3, s1_rd, s1_opcode};
        else          enc = {s1_imm[11:0], s1_rs1, s1_func3, s1_rd, s1_opcode};
      end
      FMT_S: enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_func3, s1_imm[4:0], s1_opcode};
      FMT_B: enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_func3,
                    s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: enc = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
      default: enc = NOP;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic in_shift;
  logic range_err;
  logic s1_err;
  logic ok12;
  logic ok13;
  logic ok21;

  // An immediate fits N signed bits when bits [31:N-1] are all equal.
  assign ok12     = (&imm[31:11]) || !(|imm[31:11]);
  assign ok13     = (&imm[31:12]) || !(|imm[31:12]);
  assign ok21     = (&imm[31:20]) || !(|imm[31:20]);
  assign in_shift = (fmt == FMT_I) && (opcode == OP_IMM) &&
                    ((func3 == 3'd1) || (func3 == 3'd5));

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_R: range_err = 1'b0;
      FMT_I: range_err = in_shift ? (|imm[31:5]) : !ok12;
      FMT_S: range_err = !ok12;
      FMT_B: range_err = !ok13 || imm[0];
      FMT_U: range_err = |imm[11:0];
      FMT_J: range_err = !ok21 || imm[0];
      default: range_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_err <= 1'b0;
    end else if (!stall) begin
      s1_err <= range_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      if (!stall) err <= s1_err;
      if (out_fire && err && (err_count != {ERRCNT_W{1'b1}}))
        err_count <= err_count + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= NOP;
    end else if (!stall) begin
      out_valid <= s1_valid;
      instr     <= s1_err ? NOP : enc;
    end
  end
`else
  assign err       = 1'b0;
  assign err_count = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= NOP;
    end else if (!stall) begin
      out_valid <= s1_valid;
      instr     <= enc;
    end
  end
`endif

  // The address belongs to the presented word, so it moves only when that word is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr <= BASE_ADDR;
    end else if (out_fire) begin
      out_addr <= out_addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan steps plus a randomized stream scored against a field-level model.
// A second instance with BASE_ADDR 0xFFFF_FFFC shares all inputs to cover address wrap.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] WBASE = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;

  logic        in_ready, out_valid, err;
  logic [31:0] instr, out_addr;
  logic [15:0] err_count;
  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_instr, w_out_addr;
  logic [15:0] w_err_count;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_ready = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic [31:0] m_addr = BASE;
  logic [31:0] m_addr_w = WBASE;
  logic [15:0] m_cnt = '0;

  instr_encoder #(.BASE_ADDR(BASE), .ERRCNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  instr_encoder #(.BASE_ADDR(WBASE), .ERRCNT_W(16)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .instr(w_instr),
    .out_addr(w_out_addr), .err(w_err), .err_count(w_err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {err, instr} from the field rules with plain arithmetic.
  function automatic logic [32:0] model(input fields_t t);
    logic [31:0] o, f3, f7, d, r1, r2, im, w;
    int          s;
    bit          bad, shift;
    o = 32'(t.op); f3 = 32'(t.f3); f7 = 32'(t.f7);
    d = 32'(t.rd); r1 = 32'(t.rs1); r2 = 32'(t.rs2); im = t.imm;
    s = $signed(im);
    shift = (t.fmt == 3'd1) && (t.op == 7'h13) && (t.f3 == 3'd1 || t.f3 == 3'd5);
    w = NOP;
    bad = 1'b1;
    case (t.fmt)
      3'd0: begin
        w = f7 << 25 | r2 << 20 | r1 << 15 | f3 << 12 | d << 7 | o;
        bad = 1'b0;
      end
      3'd1: begin
        if (shift) begin
          w = f7 << 25 | (im & 32'd31) << 20 | r1 << 15 | f3 << 12 | d << 7 | o;
          bad = im > 32'd31;
        end else begin
          w = (im & 32'hFFF) << 20 | r1 << 15 | f3 << 12 | d << 7 | o;
          bad = s < -2048 || s > 2047;
        end
      end
      3'd2: begin
        w = ((im >> 5) & 32'd127) << 25 | r2 << 20 | r1 << 15 | f3 << 12 |
            (im & 32'd31) << 7 | o;
        bad = s < -2048 || s > 2047;
      end
      3'd3: begin
        w = ((im >> 12) & 32'd1) << 31 | ((im >> 5) & 32'd63) << 25 | r2 << 20 |
            r1 << 15 | f3 << 12 | ((im >> 1) & 32'd15) << 8 | ((im >> 11) & 32'd1) << 7 | o;
        bad = s < -4096 || s > 4095 || im[0];
      end
      3'd4: begin
        w = (im & 32'hFFFF_F000) | d << 7 | o;
        bad = (im & 32'hFFF) != 0;
      end
      3'd5: begin
        w = ((im >> 20) & 32'd1) << 31 | ((im >> 1) & 32'd1023) << 21 |
            ((im >> 11) & 32'd1) << 20 | ((im >> 12) & 32'd255) << 12 | d << 7 | o;
        bad = s < -1048576 || s > 1048575 || im[0];
      end
      default: begin
        w = NOP;
        bad = 1'b1;
      end
    endcase
    if (CHECK_EN && bad) return {1'b1, NOP};
    return {1'b0, w};
  endfunction

  function automatic fields_t mk(input int f, input int op, input int f3, input int f7,
                                 input int d, input int r1, input int r2, input logic [31:0] im);
    fields_t t;
    t.fmt = 3'(f); t.op = 7'(op); t.f3 = 3'(f3); t.f7 = 7'(f7);
    t.rd = 5'(d); t.rs1 = 5'(r1); t.rs2 = 5'(r2); t.imm = im;
    return t;
  endfunction

  function automatic fields_t gen();
    fields_t     t;
    logic [12:0] x;
    logic [20:0] y;
    t.fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    t.op  = ($urandom_range(0, 1) == 1) ? 7'h13 : 7'($urandom);
    t.f3  = 3'($urandom); t.f7 = 7'($urandom);
    t.rd  = 5'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom);
    x = 13'($urandom);
    y = 21'($urandom);
    case ($urandom_range(0, 4))
      0: t.imm = $urandom;
      1: t.imm = {{19{x[12]}}, x};
      2: t.imm = {{11{y[20]}}, y[20:1], 1'b0};
      3: t.imm = $urandom & 32'hFFFF_F000;
      default: t.imm = 32'($urandom_range(0, 40));
    endcase
    return t;
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input fields_t t);
    in_valid = 1'b1;
    fmt = t.fmt; opcode = t.op; func3 = t.f3; func7 = t.f7;
    rd = t.rd; rs1 = t.rs1; rs2 = t.rs2; imm = t.imm;
  endtask

  task automatic put(input fields_t t);
    bit acc;
    int k;
    drive(t);
    k = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      cycle();
      k++;
    end while (!acc && k < 50);
    in_valid = 1'b0;
    check("accept_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      cycle();
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_addr = BASE;
      m_addr_w = WBASE;
      m_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        check("spurious_output", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("instr", instr, e[31:0]);
          check("err", {31'b0, err}, {31'b0, e[32]});
          check("out_addr", out_addr, m_addr);
          check("wrap_addr", w_out_addr, m_addr_w);
          check("err_count", {16'b0, err_count}, {16'b0, m_cnt});
          m_addr = m_addr + 32'd4;
          m_addr_w = m_addr_w + 32'd4;
          if (e[32] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model('{fmt, opcode, func3, func7, rd, rs1, rs2, imm}));
    end
  end

  fields_t     st[4];
  logic [31:0] st_exp[4];
  fields_t     a, b, c, d;

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_err_count", {16'b0, err_count}, 32'd0);
    cycle();

    // single R-type, latency
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(mk(0, 'h33, 0, 0, 3, 1, 2, 32'd0));
      else in_valid = 1'b0;
      @(negedge clk);
      if (i == 1) check("r_latency", {31'b0, out_valid}, 32'd0);
      if (i == 2) begin
        check("r_valid", {31'b0, out_valid}, 32'd1);
        check("r_instr", instr, 32'h002081B3);
        check("r_addr", out_addr, 32'h0);
        check("r_err", {31'b0, err}, 32'd0);
      end
      cycle();
    end
    drain();

    // back-to-back stream
    do_reset();
    st[0] = mk(1, 'h13, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    st[1] = mk(2, 'h23, 2, 0, 0, 1, 2, 32'd8);
    st[2] = mk(3, 'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFFC);
    st[3] = mk(4, 'h37, 0, 0, 5, 0, 0, 32'h1234_5000);
    st_exp = '{32'hFFF00093, 32'h0020A423, 32'hFE208EE3, 32'h123452B7};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(st[i]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (i == 1) check("s_latency", {31'b0, out_valid}, 32'd0);
      if (i >= 2) begin
        check("s_valid", {31'b0, out_valid}, 32'd1);
        check("s_instr", instr, st_exp[i-2]);
        check("s_addr", out_addr, 32'(4 * (i - 2)));
        check("s_wrap_addr", w_out_addr, WBASE + 32'(4 * (i - 2)));
      end
      cycle();
    end
    drain();

    // back-pressure mid-stream
    do_reset();
    a = gen(); b = gen(); c = gen(); d = gen();
    put(a);
    put(b);
    out_ready = 1'b0;
    drive(c);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_instr", instr, model(a)[31:0]);
      check("bp_addr", out_addr, BASE);
      cycle();
    end
    out_ready = 1'b1;
    put(c);
    put(d);
    drain();

    // range checker
    do_reset();
    put(mk(3, 'h63, 0, 0, 0, 1, 2, 32'd3));
    put(mk(7, 'h33, 0, 0, 1, 1, 1, 32'd0));
    drain();
    @(negedge clk);
    check("chk_err_count", {16'b0, err_count}, CHECK_EN ? 32'd2 : 32'd0);
    cycle();

    // reset with both stages full
    do_reset();
    put(gen());
    drive(gen());
    cycle();
    reset = 1'b1;
    in_valid = 1'b0;
    cycle();
    @(negedge clk);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_addr", out_addr, BASE);
    check("mid_rst_wrap_addr", w_out_addr, WBASE);
    cycle();
    reset = 1'b0;
    put(mk(0, 'h33, 0, 0, 3, 1, 2, 32'd0));
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid && k < 10);
      check("post_rst_addr", out_addr, BASE);
      check("post_rst_instr", instr, 32'h002081B3);
      cycle();
    end
    drain();

    // randomized stream with random back-pressure and bubbles
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        cycle();
      end else begin
        put(gen());
      end
    end
    rand_ready = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
